// File: rtl/lsu_trigger_ctl_if.sv
// rtl/lsu_trigger_ctl_if.sv - CSR configuration port and trigger event queue port of lsu_trigger_ctl
//
// Groups the two bus-like ports of the trigger controller:
//   cfg_*  : CSR-side configuration access. The write is strobed by cfg_wr_en.
//            cfg_rd_data is a combinational read of {cfg_idx, cfg_sel}.
//   evt_*  : valid/ready event stream toward the decode/exception unit.
//            evt_overflow is a sticky flag.
// Modports:
//   master : CSR + event consumer side (drives cfg_*, evt_ready)
//   slave  : the trigger controller (drives cfg_rd_data, evt_valid/mask/action/overflow)
interface lsu_trigger_ctl_if;
  logic        cfg_wr_en;
  logic [1:0]  cfg_idx;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wr_data;
  logic [31:0] cfg_rd_data;

  logic        evt_valid;
  logic [3:0]  evt_mask;
  logic        evt_action;
  logic        evt_ready;
  logic        evt_overflow;

  modport master (
    output cfg_wr_en, cfg_idx, cfg_sel, cfg_wr_data, evt_ready,
    input  cfg_rd_data, evt_valid, evt_mask, evt_action, evt_overflow
  );

  modport slave (
    input  cfg_wr_en, cfg_idx, cfg_sel, cfg_wr_data, evt_ready,
    output cfg_rd_data, evt_valid, evt_mask, evt_action, evt_overflow
  );
endinterface

// File: rtl/lsu_trigger_ctl.sv
// rtl/lsu_trigger_ctl.sv - configuration and hit sequencing for the four LSU data/address triggers
//
// Purpose:
//   Holds the per-trigger tdata1 fields and the tdata2 compare value, and drives
//   them to the LSU match datapath. Raw matches from DC3 are qualified in a DC4
//   register against enable, chaining and flush. Formed events set sticky hit
//   bits and are queued in a 2-entry in-order FIFO toward decode/exception.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   bus (slave)       cfg_* CSR access, evt_* event stream, evt_overflow
//   trig_load/store/select/match  per-trigger config, gated by enable
//   trig_tdata2       per-trigger compare value, gated by enable
//   match_dc3         raw per-trigger match from the datapath
//   lsu_valid_dc3     DC3 holds a valid non-DMA LSU op
//   flush_dc4         kill the op currently in DC4
//
// tdata1 layout: [0] load [1] store [2] select [3] match [4] chain [5] action [6] enable
module lsu_trigger_ctl (
  input  logic              clk,
  input  logic              rst,
  lsu_trigger_ctl_if.slave  bus,
  output logic [3:0]        trig_load,
  output logic [3:0]        trig_store,
  output logic [3:0]        trig_select,
  output logic [3:0]        trig_match,
  output logic [3:0][31:0]  trig_tdata2,
  input  logic [3:0]        match_dc3,
  input  logic              lsu_valid_dc3,
  input  logic              flush_dc4
);

  localparam logic [1:0] SEL_TDATA1 = 2'd0;
  localparam logic [1:0] SEL_TDATA2 = 2'd1;
  localparam logic [1:0] SEL_HIT    = 2'd2;

  // Per-trigger configuration, one bit of each vector per trigger
  logic [3:0]       cfg_load;
  logic [3:0]       cfg_store;
  logic [3:0]       cfg_select;
  logic [3:0]       cfg_match;
  logic [3:0]       cfg_chain;
  logic [3:0]       cfg_action;
  logic [3:0]       cfg_enable;
  logic [3:0][31:0] cfg_tdata2;

  logic [3:0]       hit;
  logic             overflow;
  logic [3:0]       q_dc4;

  // Event FIFO storage
  logic [1:0][3:0]  fifo_mask;
  logic [1:0]       fifo_action;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  // Write decode
  logic             wr_tdata1;
  logic             wr_tdata2;
  logic             wr_hit;
  logic [3:0]       hit_clr;
  logic             ovf_clr;

  // DC4 qualification
  logic [3:0]       fired;
  logic             evt_act_new;
  logic             form;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  logic [31:0]      rd_data;

  assign wr_tdata1 = bus.cfg_wr_en && (bus.cfg_sel == SEL_TDATA1);
  assign wr_tdata2 = bus.cfg_wr_en && (bus.cfg_sel == SEL_TDATA2);
  assign wr_hit    = bus.cfg_wr_en && (bus.cfg_sel == SEL_HIT);
  assign hit_clr   = (wr_hit && bus.cfg_wr_data[0]) ? (4'b0001 << bus.cfg_idx) : 4'b0000;
  assign ovf_clr   = wr_tdata1 && bus.cfg_wr_data[31];

  // Configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_load   <= '0;
      cfg_store  <= '0;
      cfg_select <= '0;
      cfg_match  <= '0;
      cfg_chain  <= '0;
      cfg_action <= '0;
      cfg_enable <= '0;
      cfg_tdata2 <= '0;
    end else begin
      if (wr_tdata1) begin
        cfg_load[bus.cfg_idx]   <= bus.cfg_wr_data[0];
        cfg_store[bus.cfg_idx]  <= bus.cfg_wr_data[1];
        cfg_select[bus.cfg_idx] <= bus.cfg_wr_data[2];
        cfg_match[bus.cfg_idx]  <= bus.cfg_wr_data[3];
        // Only the even trigger of a pair owns the chain bit
        cfg_chain[bus.cfg_idx]  <= bus.cfg_wr_data[4] & ~bus.cfg_idx[0];
        cfg_action[bus.cfg_idx] <= bus.cfg_wr_data[5];
        cfg_enable[bus.cfg_idx] <= bus.cfg_wr_data[6];
      end
      if (wr_tdata2) begin
        cfg_tdata2[bus.cfg_idx] <= bus.cfg_wr_data;
      end
    end
  end

  // Configuration to the match datapath, suppressed for disabled triggers
  assign trig_load   = cfg_load   & cfg_enable;
  assign trig_store  = cfg_store  & cfg_enable;
  assign trig_select = cfg_select & cfg_enable;
  assign trig_match  = cfg_match  & cfg_enable;

  always_comb begin
    trig_tdata2 = '0;
    for (int i = 0; i < 4; i++) begin
      if (cfg_enable[i]) begin
        trig_tdata2[i] = cfg_tdata2[i];
      end
    end
  end

  // DC4 qualification: chaining pairs must both match, and the action comes
  // from the lowest fired trigger (the odd one when the pair is chained).
  always_comb begin
    fired = q_dc4;
    for (int k = 0; k < 2; k++) begin
      if (cfg_chain[2*k]) begin
        fired[2*k]   = q_dc4[2*k] & q_dc4[2*k+1];
        fired[2*k+1] = q_dc4[2*k] & q_dc4[2*k+1];
      end
    end

    // Evaluated from highest to lowest index so the lowest fired trigger wins
    evt_act_new = 1'b0;
    if (fired[3]) evt_act_new = cfg_action[3];
    if (fired[2]) evt_act_new = cfg_chain[2] ? cfg_action[3] : cfg_action[2];
    if (fired[1]) evt_act_new = cfg_action[1];
    if (fired[0]) evt_act_new = cfg_chain[0] ? cfg_action[1] : cfg_action[0];
  end

  assign form = (|fired) & ~flush_dc4;
  assign full = (count == 2'd2);
  assign pop  = bus.evt_valid & bus.evt_ready;
  // A pop frees the slot the push lands in, so full+pop still accepts the event
  assign push = form & (~full | pop);
  assign drop = form & full & ~pop;

  // DC4 capture, sticky hit and overflow status
  always_ff @(posedge clk) begin
    if (rst) begin
      q_dc4    <= '0;
      hit      <= '0;
      overflow <= 1'b0;
    end else begin
      // Uses the enable in place before this edge, matching the config the
      // datapath used to generate match_dc3
      q_dc4    <= match_dc3 & {4{lsu_valid_dc3}} & cfg_enable;
      // Set dominates a same-cycle clear
      hit      <= (hit & ~hit_clr) | (form ? fired : 4'b0000);
      overflow <= (overflow & ~ovf_clr) | drop;
    end
  end

  // Event FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mask   <= '0;
      fifo_action <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mask[wr_ptr]   <= fired;
        fifo_action[wr_ptr] <= evt_act_new;
        wr_ptr              <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.evt_valid    = (count != 2'd0);
  assign bus.evt_mask     = bus.evt_valid ? fifo_mask[rd_ptr] : 4'b0000;
  assign bus.evt_action   = bus.evt_valid ? fifo_action[rd_ptr] : 1'b0;
  assign bus.evt_overflow = overflow;

  // CSR read
  always_comb begin
    rd_data = '0;
    case (bus.cfg_sel)
      SEL_TDATA1: rd_data = {25'b0,
                             cfg_enable[bus.cfg_idx],
                             cfg_action[bus.cfg_idx],
                             cfg_chain[bus.cfg_idx],
                             cfg_match[bus.cfg_idx],
                             cfg_select[bus.cfg_idx],
                             cfg_store[bus.cfg_idx],
                             cfg_load[bus.cfg_idx]};
      SEL_TDATA2: rd_data = cfg_tdata2[bus.cfg_idx];
      SEL_HIT:    rd_data = {31'b0, hit[bus.cfg_idx]};
      default:    rd_data = '0;
    endcase
    rd_data[31] = 1'b0;
  end

  assign bus.cfg_rd_data = rd_data;

endmodule

// File: tb/tb_lsu_trigger_ctl.sv
// tb/tb_lsu_trigger_ctl.sv - self-checking bench for lsu_trigger_ctl
module tb_lsu_trigger_ctl;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       trig_load;
  logic [3:0]       trig_store;
  logic [3:0]       trig_select;
  logic [3:0]       trig_match;
  logic [3:0][31:0] trig_tdata2;
  logic [3:0]       match_dc3;
  logic             lsu_valid_dc3;
  logic             flush_dc4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_trigger_ctl_if bus ();

  lsu_trigger_ctl dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .trig_load     (trig_load),
    .trig_store    (trig_store),
    .trig_select   (trig_select),
    .trig_match    (trig_match),
    .trig_tdata2   (trig_tdata2),
    .match_dc3     (match_dc3),
    .lsu_valid_dc3 (lsu_valid_dc3),
    .flush_dc4     (flush_dc4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: tdata1 words, tdata2, hit bits, the qualified DC4
  // vector and a queue of {action, mask} events.
  logic [31:0] m_t1 [4];
  logic [31:0] m_t2 [4];
  logic [3:0]  m_hit = '0;
  logic [3:0]  m_q   = '0;
  logic        m_ovf = 1'b0;
  logic [4:0]  m_fifo [$];

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_t1[i] = '0;
      m_t2[i] = '0;
    end
  end

  function automatic logic [31:0] m_read(input logic [1:0] idx, input logic [1:0] sel);
    case (sel)
      2'd0:    return m_t1[idx];
      2'd1:    return m_t2[idx] & 32'h7fff_ffff;
      2'd2:    return {31'b0, m_hit[idx]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [3:0]  f;
    logic [3:0]  nq;
    logic [3:0]  en;
    logic        a;
    logic        formed;
    logic        pop;
    logic [31:0] wd;
    int          lo;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_t1[i] = '0;
        m_t2[i] = '0;
      end
      m_hit = '0;
      m_q   = '0;
      m_ovf = 1'b0;
      m_fifo.delete();
    end else begin
      f = m_q;
      for (int k = 0; k < 4; k += 2) begin
        if (m_t1[k][4]) begin
          f[k]   = m_q[k] & m_q[k+1];
          f[k+1] = f[k];
        end
      end
      formed = (f != 4'b0) && !flush_dc4;
      lo = -1;
      for (int i = 0; i < 4; i++) if (f[i] && lo < 0) lo = i;
      a = 1'b0;
      if (lo >= 0) begin
        if ((lo % 2 == 0) && m_t1[lo][4]) a = m_t1[lo+1][5];
        else a = m_t1[lo][5];
      end
      pop = (m_fifo.size() > 0) && bus.evt_ready;
      en = {m_t1[3][6], m_t1[2][6], m_t1[1][6], m_t1[0][6]};
      nq = match_dc3 & {4{lsu_valid_dc3}} & en;

      wd = bus.cfg_wr_data;
      if (bus.cfg_wr_en) begin
        case (bus.cfg_sel)
          2'd0: begin
            m_t1[bus.cfg_idx] = wd & 32'h0000_007f;
            if (bus.cfg_idx[0]) m_t1[bus.cfg_idx][4] = 1'b0;
            if (wd[31]) m_ovf = 1'b0;
          end
          2'd1: m_t2[bus.cfg_idx] = wd;
          2'd2: if (wd[0]) m_hit[bus.cfg_idx] = 1'b0;
          default: ;
        endcase
      end

      if (pop) void'(m_fifo.pop_front());
      if (formed) begin
        m_hit = m_hit | f;
        if (m_fifo.size() < 2) m_fifo.push_back({a, f});
        else m_ovf = 1'b1;
      end
      m_q = nq;
    end
  end

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    logic [3:0] en;
    #1;
    en = {m_t1[3][6], m_t1[2][6], m_t1[1][6], m_t1[0][6]};
    chk("evt_valid", bus.evt_valid, m_fifo.size() > 0);
    chk("evt_mask", bus.evt_mask, (m_fifo.size() > 0) ? m_fifo[0][3:0] : 4'b0);
    chk("evt_action", bus.evt_action, (m_fifo.size() > 0) ? m_fifo[0][4] : 1'b0);
    chk("evt_overflow", bus.evt_overflow, m_ovf);
    chk("trig_load", trig_load, {m_t1[3][0], m_t1[2][0], m_t1[1][0], m_t1[0][0]} & en);
    chk("trig_store", trig_store, {m_t1[3][1], m_t1[2][1], m_t1[1][1], m_t1[0][1]} & en);
    chk("trig_select", trig_select, {m_t1[3][2], m_t1[2][2], m_t1[1][2], m_t1[0][2]} & en);
    chk("trig_match", trig_match, {m_t1[3][3], m_t1[2][3], m_t1[1][3], m_t1[0][3]} & en);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("trig_tdata2[%0d]", i), trig_tdata2[i], en[i] ? m_t2[i] : 32'h0);
    end
    chk("cfg_rd_data", bus.cfg_rd_data, m_read(bus.cfg_idx, bus.cfg_sel));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [1:0] sel, input logic [31:0] d);
    @(negedge clk);
    bus.cfg_wr_en   = 1'b1;
    bus.cfg_idx     = idx;
    bus.cfg_sel     = sel;
    bus.cfg_wr_data = d;
    @(negedge clk);
    bus.cfg_wr_en   = 1'b0;
    bus.cfg_wr_data = '0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] idx, input logic [1:0] sel,
                        input logic [31:0] exp);
    bus.cfg_idx = idx;
    bus.cfg_sel = sel;
    #1;
    chk(name, bus.cfg_rd_data, exp);
  endtask

  initial begin
    rst             = 1'b1;
    bus.cfg_wr_en   = 1'b0;
    bus.cfg_idx     = 2'd0;
    bus.cfg_sel     = 2'd0;
    bus.cfg_wr_data = '0;
    bus.evt_ready   = 1'b1;
    match_dc3       = '0;
    lsu_valid_dc3   = 1'b0;
    flush_dc4       = 1'b0;
    repeat (3) step();
    chk("rst_evt_valid", bus.evt_valid, 1'b0);
    chk("rst_trig_load", trig_load, 4'b0);
    chk("rst_ovf", bus.evt_overflow, 1'b0);
    rd_chk("rst_rd_t1", 2'd0, 2'd0, 32'h0);
    rst = 1'b0;
    step();

    // Single load trigger
    cfg_write(2'd0, 2'd0, 32'h41);
    match_dc3 = 4'b0001; lsu_valid_dc3 = 1'b1;
    step();
    match_dc3 = 4'b0000; lsu_valid_dc3 = 1'b0;
    step();
    chk("t1_valid", bus.evt_valid, 1'b1);
    chk("t1_mask", bus.evt_mask, 4'b0001);
    chk("t1_action", bus.evt_action, 1'b0);
    chk("t1_trig_load", trig_load, 4'b0001);
    rd_chk("t1_hit0", 2'd0, 2'd2, 32'h1);
    rd_chk("t1_rd_t1", 2'd0, 2'd0, 32'h41);

    // Chained pair 0/1
    cfg_write(2'd0, 2'd0, 32'h51);
    cfg_write(2'd1, 2'd0, 32'h61);
    rd_chk("chain_rd_t1_0", 2'd0, 2'd0, 32'h51);
    match_dc3 = 4'b0001; lsu_valid_dc3 = 1'b1;
    step();
    match_dc3 = 4'b0000; lsu_valid_dc3 = 1'b0;
    step();
    chk("chain1_valid", bus.evt_valid, 1'b0);
    match_dc3 = 4'b0011; lsu_valid_dc3 = 1'b1;
    step();
    match_dc3 = 4'b0000; lsu_valid_dc3 = 1'b0;
    step();
    chk("chain2_valid", bus.evt_valid, 1'b1);
    chk("chain2_mask", bus.evt_mask, 4'b0011);
    chk("chain2_action", bus.evt_action, 1'b1);

    // Chain bit on an odd trigger reads back 0
    cfg_write(2'd1, 2'd0, 32'h71);
    rd_chk("odd_chain", 2'd1, 2'd0, 32'h61);

    // Flushed hit
    cfg_write(2'd0, 2'd0, 32'h41);
    cfg_write(2'd0, 2'd2, 32'h1);
    rd_chk("flush_hit_cleared", 2'd0, 2'd2, 32'h0);
    match_dc3 = 4'b0001; lsu_valid_dc3 = 1'b1;
    step();
    match_dc3 = 4'b0000; lsu_valid_dc3 = 1'b0; flush_dc4 = 1'b1;
    step();
    flush_dc4 = 1'b0;
    chk("flush_valid", bus.evt_valid, 1'b0);
    rd_chk("flush_hit0", 2'd0, 2'd2, 32'h0);

    // Overflow with consumer stalled
    cfg_write(2'd2, 2'd0, 32'h41);
    cfg_write(2'd1, 2'd1, 32'h1234_5678);
    chk("tdata2_out", trig_tdata2[1], 32'h1234_5678);
    bus.evt_ready = 1'b0;
    lsu_valid_dc3 = 1'b1;
    match_dc3 = 4'b0001; step();
    match_dc3 = 4'b0010; step();
    match_dc3 = 4'b0100; step();
    match_dc3 = 4'b0000; lsu_valid_dc3 = 1'b0; step();
    chk("ovf_valid", bus.evt_valid, 1'b1);
    chk("ovf_head_mask", bus.evt_mask, 4'b0001);
    chk("ovf_head_action", bus.evt_action, 1'b0);
    chk("ovf_flag", bus.evt_overflow, 1'b1);
    step();
    chk("ovf_stall_mask", bus.evt_mask, 4'b0001);
    bus.evt_ready = 1'b1;
    step();
    chk("ovf_pop2_mask", bus.evt_mask, 4'b0010);
    chk("ovf_pop2_action", bus.evt_action, 1'b1);
    step();
    chk("ovf_empty", bus.evt_valid, 1'b0);
    cfg_write(2'd0, 2'd0, 32'h8000_0041);
    chk("ovf_cleared", bus.evt_overflow, 1'b0);
    rd_chk("ovf_rd_bit31", 2'd0, 2'd0, 32'h41);

    // Same-cycle hit clear and new hit on trigger 2
    cfg_write(2'd2, 2'd2, 32'h1);
    rd_chk("hc_pre", 2'd2, 2'd2, 32'h0);
    match_dc3 = 4'b0100; lsu_valid_dc3 = 1'b1;
    step();
    match_dc3 = 4'b0000; lsu_valid_dc3 = 1'b0;
    bus.cfg_wr_en = 1'b1; bus.cfg_idx = 2'd2; bus.cfg_sel = 2'd2; bus.cfg_wr_data = 32'h1;
    step();
    bus.cfg_wr_en = 1'b0; bus.cfg_wr_data = '0;
    rd_chk("hc_set_wins", 2'd2, 2'd2, 32'h1);

    // Disabled trigger 3
    cfg_write(2'd3, 2'd1, 32'h0EAD_BEEF);
    cfg_write(2'd3, 2'd0, 32'h21);
    chk("dis_trig_load", trig_load, 4'b0111);
    chk("dis_tdata2", trig_tdata2[3], 32'h0);
    rd_chk("dis_rd_t2", 2'd3, 2'd1, 32'h0EAD_BEEF);
    match_dc3 = 4'b1000; lsu_valid_dc3 = 1'b1;
    step();
    match_dc3 = 4'b0000; lsu_valid_dc3 = 1'b0;
    step();
    chk("dis_valid", bus.evt_valid, 1'b0);
    rd_chk("dis_hit3", 2'd3, 2'd2, 32'h0);

    // Reset with two events queued and one in flight
    bus.evt_ready = 1'b0;
    lsu_valid_dc3 = 1'b1;
    match_dc3 = 4'b0001; step();
    match_dc3 = 4'b0010; step();
    match_dc3 = 4'b0000; lsu_valid_dc3 = 1'b0; step();
    chk("rq_valid", bus.evt_valid, 1'b1);
    rst = 1'b1; match_dc3 = 4'b0001; lsu_valid_dc3 = 1'b1;
    step();
    chk("rq_valid_after", bus.evt_valid, 1'b0);
    chk("rq_trig_load", trig_load, 4'b0);
    rd_chk("rq_rd_t1", 2'd0, 2'd0, 32'h0);
    rd_chk("rq_rd_t2", 2'd1, 2'd1, 32'h0);
    rst = 1'b0; match_dc3 = 4'b0000; lsu_valid_dc3 = 1'b0; bus.evt_ready = 1'b1;
    repeat (3) step();
    chk("rq_no_event", bus.evt_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
